// File: rtl/pipe_addsub_nbit.sv
// Pipelined N-bit two's-complement adder/subtractor: the carry chain is cut into
// STAGES equal ripple-carry chunks with registered carries and a valid/ready pipeline.
module pipe_addsub_nbit #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
  localparam int W           = N / SAFE_STAGES;

  if ((STAGES < 1) || (N % SAFE_STAGES != 0)) begin : g_param_check
    $error("pipe_addsub_nbit: STAGES must be >= 1 and divide N");
  end

  // One ripple-carry chunk built from full-adder cells; returns {carry_out, sum}.
  function automatic logic [W:0] ripple(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c_in);
    logic [W-1:0] sum;
    logic         c;
    c = c_in;
    for (int i = 0; i < W; i++) begin
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, sum};
  endfunction

  logic [N-1:0]        b_eff;
  logic                c_eff;
  logic [STAGES-1:0]   vld;
  logic [STAGES-1:0]   load;

  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | cin;

  // A stage may load when it is empty or anything at or after it can drain;
  // the chain is driven only by out_ready and valid bits, never by in_valid.
  always_comb begin
    logic acc;
    // NOTE: blocking assignments in always_comb model combinational ordering;
    // every variable is given a value before it is read, so no latch is inferred.
    acc  = out_ready;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc     = acc | ~vld[k];
      load[k] = acc;
    end
  end

  assign in_ready = load[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * W;
    localparam int HI = (k + 1) * W;

    logic            vld_q;
    logic            c_q;
    logic [HI-1:0]   sum_q;
    logic [HI-1:0]   sum_d;
    logic [N-LO-1:0] op_a;
    logic [N-LO-1:0] op_b;
    logic            ci;
    logic            in_v;
    logic [W:0]      chunk;

    if (k == 0) begin : g_head
      assign op_a  = a;
      assign op_b  = b_eff;
      assign ci    = c_eff;
      assign in_v  = in_valid;
      assign sum_d = chunk[W-1:0];
    end else begin : g_body
      assign op_a  = g_stage[k-1].g_rest.a_rest_q;
      assign op_b  = g_stage[k-1].g_rest.b_rest_q;
      assign ci    = g_stage[k-1].c_q;
      assign in_v  = vld[k-1];
      assign sum_d = {chunk[W-1:0], g_stage[k-1].sum_q};
    end

    assign chunk  = ripple(op_a[W-1:0], op_b[W-1:0], ci);
    assign vld[k] = vld_q;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (load[k]) begin
        vld_q <= in_v;
        if (in_v) begin
          c_q   <= chunk[W];
          sum_q <= sum_d;
        end
      end
    end

    if (HI < N) begin : g_rest
      logic [N-HI-1:0] a_rest_q;
      logic [N-HI-1:0] b_rest_q;

      // NOTE: operand carry registers are qualified by their stage valid bit,
      // so they are deliberately left without reset.
      always_ff @(posedge clk) begin
        if (load[k] && in_v) begin
          a_rest_q <= op_a[N-LO-1:W];
          b_rest_q <= op_b[N-LO-1:W];
        end
      end
    end else begin : g_tail
      logic zero_q;
      logic ovf_q;

      // Flags come from the complete sum; op_a/op_b top bits are a[N-1], b_eff[N-1].
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          zero_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (load[k] && in_v) begin
          zero_q <= (sum_d == '0);
          ovf_q  <= (op_a[W-1] == op_b[W-1]) && (sum_d[N-1] != op_a[W-1]);
        end
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign s         = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;
  assign zero      = g_stage[STAGES-1].g_tail.zero_q;

endmodule

// File: tb/tb_pipe_addsub_nbit.sv
// Self-checking bench for pipe_addsub_nbit: directed vector table, backpressure and
// reset sequences on N=32/STAGES=4, plus randomized streaming on three configurations.
module tb_pipe_addsub_nbit;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid[3];
  logic        in_ready[3];
  logic [31:0] a[3];
  logic [31:0] b[3];
  logic        cin[3];
  logic        sub[3];
  logic        out_valid[3];
  logic        out_ready[3];
  logic        cout[3];
  logic        ovf[3];
  logic        zero[3];
  logic [31:0] s0;
  logic [7:0]  s1;
  logic [15:0] s2;

  pipe_addsub_nbit #(.N(32), .STAGES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .s(s0), .cout(cout[0]), .ovf(ovf[0]), .zero(zero[0]));

  pipe_addsub_nbit #(.N(8), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1][7:0]), .b(b[1][7:0]), .cin(cin[1]), .sub(sub[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .s(s1), .cout(cout[1]), .ovf(ovf[1]), .zero(zero[1]));

  pipe_addsub_nbit #(.N(16), .STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2][15:0]), .b(b[2][15:0]), .cin(cin[2]), .sub(sub[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .s(s2), .cout(cout[2]), .ovf(ovf[2]), .zero(zero[2]));

  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];
  bit   acc;
  bit   emit;
  int   emitted;

  function automatic int width_of(int d);
    case (d)
      0:       return 32;
      1:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [31:0] s_of(int d);
    case (d)
      0:       return s0;
      1:       return {24'd0, s1};
      default: return {16'd0, s2};
    endcase
  endfunction

  // Reference: signed/unsigned arithmetic on wide integers, then reduce modulo 2^nb.
  function automatic res_t model(int nb, logic [31:0] av, logic [31:0] bv, bit sb, bit ci);
    res_t   res;
    longint mask = (longint'(1) << nb) - 1;
    longint lim  = longint'(1) << (nb - 1);
    longint ua   = longint'(av);
    longint ub   = longint'(bv);
    longint cl   = ci;
    longint sa   = (ua >= lim) ? ua - 2 * lim : ua;
    longint sbv  = (ub >= lim) ? ub - 2 * lim : ub;
    longint r    = sb ? sa - sbv : sa + sbv + cl;
    longint u    = sb ? ua - ub : ua + ub + cl;
    res.s    = 32'(u & mask);
    res.cout = sb ? (ua >= ub) : (((ua + ub + cl) >> nb) != 0);
    res.ovf  = (r >= lim) || (r < -lim);
    res.zero = (res.s == 32'd0);
    return res;
  endfunction

  function automatic logic [31:0] rnd(int nb);
    logic [31:0] mask;
    mask = (nb == 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
    case ($urandom % 5)
      0:       return 32'd0;
      1:       return mask;
      2:       return 32'd1 << (nb - 1);
      default: return $urandom & mask;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle on DUT d: drive at the falling edge, observe the handshake
  // just after, and score any emitted result against the model queue.
  task automatic cycle(input int d, input bit iv, input logic [31:0] av, input logic [31:0] bv,
                       input bit sb, input bit ci, input bit ordy);
    res_t r;
    @(negedge clk);
    in_valid[d]  = iv;
    a[d]         = av;
    b[d]         = bv;
    sub[d]       = sb;
    cin[d]       = ci;
    out_ready[d] = ordy;
    #1;
    acc  = iv && in_ready[d];
    emit = out_valid[d] && ordy;
    if (emit) begin
      emitted++;
      check("result_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("s",    s_of(d), r.s);
        check("cout", cout[d], r.cout);
        check("ovf",  ovf[d],  r.ovf);
        check("zero", zero[d], r.zero);
      end
    end
    if (acc) exp_q.push_back(model(width_of(d), av, bv, sb, ci));
  endtask

  vec_t        vecs[8];
  logic [31:0] bp_a[8];
  logic [31:0] bp_b[8];
  int          lat;
  int          acc_cnt;
  int          sent;
  int          cyc;
  int          stale;

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h1,        1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h7FFF_FFFF, 32'h1,        1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_00FF, 32'h1,        1'b0, 1'b1, 32'h0000_0101, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h5,         32'h7,        1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h1,        1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'h1234,      32'h1234,     1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'hA,         32'h3,        1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{32'h00FF_FFFF, 32'h1,        1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};

    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      a[d]         = '0;
      b[d]         = '0;
      sub[d]       = 1'b0;
      cin[d]       = 1'b0;
      out_ready[d] = 1'b1;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_out_valid", out_valid[d], 0);
      check("rst_s",         s_of(d), 0);
      check("rst_cout",      cout[d], 0);
      check("rst_ovf",       ovf[d], 0);
      check("rst_zero",      zero[d], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready[0], 1);

    // Directed table: one beat at a time, latency and every flag checked.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid[0]  = 1'b1;
      a[0]         = vecs[i].a;
      b[0]         = vecs[i].b;
      sub[0]       = vecs[i].sub;
      cin[0]       = vecs[i].cin;
      out_ready[0] = 1'b1;
      #1;
      check("vec_in_ready", in_ready[0], 1);
      lat = 0;
      do begin
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1;
        lat++;
      end while (!out_valid[0] && lat < 12);
      check("vec_latency", lat, 4);
      check("vec_s",    s0,      vecs[i].s);
      check("vec_cout", cout[0], vecs[i].cout);
      check("vec_ovf",  ovf[0],  vecs[i].ovf);
      check("vec_zero", zero[0], vecs[i].zero);
    end
    @(negedge clk);

    // Backpressure: six back-to-back beats into a stalled pipe.
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = 32'h1111_1111 * (i + 1);
      bp_b[i] = 32'h0101_0101 * (i + 3);
    end
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1'b1, bp_a[acc_cnt], bp_b[acc_cnt], acc_cnt[0], 1'b0, 1'b0);
      if (acc) acc_cnt++;
    end
    check("bp_accepted", acc_cnt, 4);
    check("bp_in_ready_low", in_ready[0], 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1'b1, bp_a[acc_cnt], bp_b[acc_cnt], acc_cnt[0], 1'b0, 1'b0);
      if (acc) acc_cnt++;
      check("bp_hold_valid", out_valid[0], 1);
      check("bp_hold_s", s0, (exp_q.size() > 0) ? exp_q[0].s : 32'hX);
    end
    emitted = 0;
    for (int i = 0; i < 20 && emitted < 6; i++) begin
      cycle(0, acc_cnt < 6, bp_a[acc_cnt], bp_b[acc_cnt], acc_cnt[0], 1'b0, 1'b1);
      if (acc) acc_cnt++;
      if (i == 0) check("bp_full_shift_ready", in_ready[0], 1);
      if (i < 4) check("bp_one_per_cycle", emit, 1);
    end
    check("bp_total_accepted", acc_cnt, 6);
    check("bp_total_emitted", emitted, 6);
    in_valid[0] = 1'b0;

    // Reset with three beats in flight and the output stalled.
    exp_q.delete();
    for (int i = 0; i < 3; i++) cycle(0, 1'b1, rnd(32), rnd(32), 1'b0, 1'b0, 1'b0);
    cycle(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("mid_out_valid_before_rst", out_valid[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid[0], 0);
    check("mid_rst_s", s0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_in_ready", in_ready[0], 1);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      if (out_valid[0]) stale++;
    end
    check("mid_rst_no_stale", stale, 0);

    // Randomized streaming with random valid/ready on every configuration.
    for (int d = 0; d < 3; d++) begin
      exp_q.delete();
      sent    = 0;
      emitted = 0;
      cyc     = 0;
      while ((sent < 100 || emitted < 100) && cyc < 3000) begin
        cycle(d, (sent < 100) && ($urandom % 4 != 0), rnd(width_of(d)), rnd(width_of(d)),
              1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 4 != 0));
        if (acc) sent++;
        cyc++;
      end
      in_valid[d] = 1'b0;
      check("stream_sent", sent, 100);
      check("stream_emitted", emitted, 100);
      check("stream_drained", exp_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
